// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks survivor decisions backwards from an end state/address
// and assembles the decoded bit block in time order (bit 0 = oldest step).
module viterbi_traceback #(
  parameter int SBITS = 3,
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [SBITS-1:0]  Start_State,
  input  logic [ADDR-1:0]   End_Addr,
  input  logic [ADDR:0]     Len,
  input  logic              Mem_Gnt,
  output logic              RdEn,
  output logic [ADDR-1:0]   Address,
  input  logic [WIDTH-1:0]  RdData,
  output logic              Busy,
  output logic [DEPTH-1:0]  Dec_Data,
  output logic              Dec_VLD,
  output logic [SBITS-1:0]  Final_State
);

  localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] ONE_L   = (ADDR+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t           r_st, w_st_nx;
  logic [ADDR:0]    r_icnt, r_ccnt, w_len;
  logic [ADDR-1:0]  r_addr, w_kidx;
  logic [SBITS-1:0] r_ts, w_ts_nx, r_final;
  logic [DEPTH-1:0] r_dec;
  logic             r_pend, r_vld;
  logic             w_start, w_last_iss, w_last_con;

  assign w_len      = (Len > DEPTH_L) ? DEPTH_L : Len;
  assign w_start    = Start && (Len != '0) && (r_st == S_IDLE);
  assign RdEn       = (r_st == S_ISSUE) && Mem_Gnt;
  assign w_last_iss = RdEn && (r_icnt == ONE_L);
  assign w_last_con = r_pend && (r_ccnt == ONE_L);
  // Counts never exceed DEPTH, so k-1 always fits the bit index.
  assign w_kidx     = ADDR'(r_ccnt - ONE_L);
  // Shift the decision bit in: the predecessor state of the previous step.
  assign w_ts_nx    = {r_ts[SBITS-2:0], RdData[r_ts]};

  assign Address     = r_addr;
  assign Busy        = (r_st != S_IDLE);
  assign Dec_Data    = r_dec;
  assign Dec_VLD     = r_vld;
  assign Final_State = r_final;

  always_comb begin
    w_st_nx = r_st;
    case (r_st)
      S_IDLE:  if (w_start)    w_st_nx = S_ISSUE;
      S_ISSUE: if (w_last_iss) w_st_nx = S_DRAIN;
      S_DRAIN: if (w_last_con) w_st_nx = S_IDLE;
      default: w_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_st <= S_IDLE;
    else      r_st <= w_st_nx;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_icnt  <= '0;
      r_ccnt  <= '0;
      r_addr  <= '0;
      r_ts    <= '0;
      r_final <= '0;
      r_dec   <= '0;
      r_pend  <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      // Read data arrives one cycle after the issue, whatever the grant does then.
      r_pend <= RdEn;
      if (w_start) begin
        r_dec  <= '0;
        r_addr <= End_Addr;
        r_ts   <= Start_State;
        r_icnt <= w_len;
        r_ccnt <= w_len;
      end else begin
        if (RdEn) begin
          r_addr <= r_addr - 1'b1;
          r_icnt <= r_icnt - ONE_L;
        end
        if (r_pend) begin
          r_dec[w_kidx] <= r_ts[SBITS-1];
          r_ts          <= w_ts_nx;
          r_ccnt        <= r_ccnt - ONE_L;
          if (w_last_con) begin
            r_final <= w_ts_nx;
            r_vld   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/viterbi_traceback.md
# viterbi_traceback

Traceback unit of the Viterbi decoder. Reads survivor decision words from the survivor register file (one word per trellis step, one decision bit per state), walks the trellis backwards from a given end state and step address, and delivers the decoded bit block in time order. Sits downstream of the add-compare-select stage and shares the register file's single port through an external arbiter grant.

## Interface
- SBITS, 3, state width; number of states = 2**SBITS
- WIDTH, 8, decision word width; must equal 2**SBITS
- DEPTH, 64, survivor memory depth (steps)
- ADDR, 6, address width; DEPTH = 2**ADDR
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- Start  in  1  pulse; samples Start_State, End_Addr, Len
- Start_State  in  SBITS  trellis state at newest step
- End_Addr  in  ADDR  address of newest decision word
- Len  in  ADDR+1  steps to trace, 1..DEPTH
- Mem_Gnt  in  1  arbiter grant of register file port
- RdEn  out  1  register file read enable
- Address  out  ADDR  register file address
- RdData  in  WIDTH  register file read data, valid one cycle after RdEn
- Busy  out  1  traceback in progress
- Dec_Data  out  DEPTH  decoded bits, bit i = step i counted from oldest
- Dec_VLD  out  1  one-cycle pulse, Dec_Data/Final_State valid
- Final_State  out  SBITS  state reached after Len steps

## Operation
- Reset: RdEn, Busy, Dec_VLD = 0; Address, Dec_Data, Final_State = 0; FSM to IDLE.
- FSM: IDLE -> ISSUE on Start with Len != 0 and not Busy; ISSUE -> DRAIN after Len reads issued; DRAIN -> IDLE after last word consumed, pulsing Dec_VLD.
- Start with Len = 0 ignored. Len > DEPTH clamped to DEPTH. Start while Busy ignored.
- On accepted Start: Dec_Data cleared, Address <= End_Addr, trace state <= Start_State, issue/consume counters <= Len.
- ISSUE: RdEn = Mem_Gnt (combinational). Each cycle RdEn high, Address decrements modulo DEPTH at next edge (0 -> DEPTH-1). Mem_Gnt low: no read, Address held.
- Consume: registered rd_pend = RdEn of previous cycle. When rd_pend: d = RdData[state]; decoded bit = state[SBITS-1]; written to Dec_Data[k-1], k = remaining consume count; state <= {state[SBITS-2:0], d}; k decrements.
- Bits of Dec_Data at index >= Len stay 0.
- Block never drives WrEn; arbiter guarantees register file WrEn low while Mem_Gnt high.
- Final_State = trace state after last consume, updated with Dec_VLD.

## Timing
- Start sampled at edge E0; Busy high from E0.
- Mem_Gnt held high: RdEn high for exactly Len consecutive cycles starting after E0; Address = End_Addr in first RdEn cycle.
- Last word consumed at edge E(Len+1); Dec_VLD high and Busy low in the cycle after, for one cycle; Dec_Data/Final_State hold until next accepted Start.
- Each Mem_Gnt-low cycle during ISSUE delays Dec_VLD by exactly one cycle; results unchanged.
- Mem_Gnt low in the cycle after a read does not affect consumption of that read (register file holds RdData).
- RST low mid-traceback: all outputs to reset values immediately (RdEn drops asynchronously); no Dec_VLD for aborted run.
- Start in the Dec_VLD cycle accepted (Busy already low).

## Test plan
- All-zero decisions, Start_State=3'b101, End_Addr=5, Len=3 -> addresses 5,4,3; Dec_Data=...000101, Final_State=3'b000, Dec_VLD 4 cycles after start edge.
- All-ones decisions, Start_State=3'b000, End_Addr=10, Len=4 -> Dec_Data=...0001, Final_State=3'b111.
- End_Addr=1, Len=4 -> Address sequence 1,0,63,62; RdEn exactly 4 cycles.
- Mem_Gnt low 3 cycles mid-ISSUE, Len=8 -> Dec_VLD 3 cycles later than ungranted-stall run, identical Dec_Data/Final_State.
- Start pulsed while Busy with different inputs -> ignored; result matches first request. Len=0 -> no activity, Busy stays 0.
- RST low at 2nd read of Len=16 run -> RdEn/Busy/Dec_Data/Final_State 0 same cycle, no Dec_VLD; new Start after release completes normally.
